// File: rtl/contador_distancia_if.sv
// Echo-pulse measurement bus: the raw echo input and the distance results.
// The counter drives the results through the master modport.
interface contador_distancia_if #(
  parameter int N       = 12,
  parameter int DIGITOS = 3
);
  logic                 pulso;
  logic [4*DIGITOS-1:0] digitos;
  logic [N-1:0]         medida;
  logic                 pronto;
  logic                 erro;
  logic                 ocupado;

  modport master (input pulso, output digitos, medida, pronto, erro, ocupado);
  modport slave  (output pulso, input digitos, medida, pronto, erro, ocupado);
endinterface

// File: rtl/contador_distancia.sv
// Echo-width distance counter: binary and BCD results with timeout detection.
// Optional round-half-up is enabled by defining CONTADOR_DISTANCIA_ARREDONDA_EN.
module contador_distancia #(
  parameter int R          = 2941,
  parameter int N          = 12,
  parameter int DIGITOS    = 3,
  parameter int TIMEOUT_CM = 400
) (
  input  logic                 clock,
  input  logic                 reset,
  contador_distancia_if.master bus
);

  localparam int            TW    = (R > 1) ? $clog2(R) : 1;
  localparam logic [TW-1:0] T_MAX = TW'(R - 1);
  localparam logic [N-1:0]  U_MAX = N'(TIMEOUT_CM);
`ifdef CONTADOR_DISTANCIA_ARREDONDA_EN
  localparam logic [TW-1:0] T_HALF = TW'(R / 2);
`endif

  typedef enum logic [2:0] {
    ESPERA,
    MEDINDO,
    ARREDONDA,
    CONCLUI,
    ERRO
  } estado_t;

  estado_t              state_q, state_d;
  logic                 pulso_r_q, pulso_atr_q;
  logic [TW-1:0]        t_q, t_d;
  logic [N-1:0]         u_q, u_d;
  logic [4*DIGITOS-1:0] b_q, b_d;
  logic [N-1:0]         medida_q, medida_d;
  logic [4*DIGITOS-1:0] digitos_q, digitos_d;
  logic                 erro_q, erro_d;
  logic                 pronto_q, pronto_d;
  logic                 subida;

  // Cascaded decimal increment, so the BCD count never needs a conversion.
  function automatic logic [4*DIGITOS-1:0] bcd_inc(input logic [4*DIGITOS-1:0] v);
    logic [4*DIGITOS-1:0] r;
    logic                 carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITOS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign subida = pulso_r_q & ~pulso_atr_q;

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    u_d       = u_q;
    b_d       = b_q;
    medida_d  = medida_q;
    digitos_d = digitos_q;
    erro_d    = erro_q;
    case (state_q)
      ESPERA: begin
        t_d = '0;
        u_d = '0;
        b_d = '0;
        if (subida) begin
          state_d = MEDINDO;
          erro_d  = 1'b0;
        end
      end
      MEDINDO: begin
        // The timeout check comes first so it wins over a pulse ending now.
        if (u_q == U_MAX) begin
          state_d = ERRO;
        end else if (!pulso_r_q) begin
          state_d = ARREDONDA;
        end else if (t_q == T_MAX) begin
          t_d = '0;
          u_d = u_q + N'(1);
          b_d = bcd_inc(b_q);
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      ARREDONDA: begin
`ifdef CONTADOR_DISTANCIA_ARREDONDA_EN
        if ((t_q >= T_HALF) && (u_q < U_MAX)) begin
          u_d = u_q + N'(1);
          b_d = bcd_inc(b_q);
        end
`endif
        medida_d  = u_d;
        digitos_d = b_d;
        state_d   = CONCLUI;
      end
      CONCLUI: state_d = ESPERA;
      ERRO: begin
        if (!pulso_r_q) state_d = ESPERA;
      end
      default: state_d = ESPERA;
    endcase
    if (state_d == ERRO) erro_d = 1'b1;
    pronto_d = (state_d == CONCLUI) || ((state_d == ERRO) && (state_q != ERRO));
  end

  // The edge detector resets high so a pulse already present at release is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ESPERA;
      pulso_r_q   <= 1'b1;
      pulso_atr_q <= 1'b1;
      t_q         <= '0;
      u_q         <= '0;
      b_q         <= '0;
      medida_q    <= '0;
      digitos_q   <= '0;
      erro_q      <= 1'b0;
      pronto_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulso_r_q   <= bus.pulso;
      pulso_atr_q <= pulso_r_q;
      t_q         <= t_d;
      u_q         <= u_d;
      b_q         <= b_d;
      medida_q    <= medida_d;
      digitos_q   <= digitos_d;
      erro_q      <= erro_d;
      pronto_q    <= pronto_d;
    end
  end

  assign bus.medida  = medida_q;
  assign bus.digitos = digitos_q;
  assign bus.erro    = erro_q;
  assign bus.pronto  = pronto_q;
  assign bus.ocupado = (state_q == MEDINDO) || (state_q == ARREDONDA);

endmodule

// File: tb/tb_contador_distancia.sv
// Bench for contador_distancia using a scaled-down R/TIMEOUT so runs stay short.
// The reference model derives results from pulse length with plain arithmetic.
module tb_contador_distancia;

  localparam int R          = 7;
  localparam int N          = 8;
  localparam int DIGITOS    = 3;
  localparam int TIMEOUT_CM = 150;
`ifdef CONTADOR_DISTANCIA_ARREDONDA_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  contador_distancia_if #(.N(N), .DIGITOS(DIGITOS)) bus ();

  contador_distancia #(
    .R(R), .N(N), .DIGITOS(DIGITOS), .TIMEOUT_CM(TIMEOUT_CM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int testsRun    = 0;
  int testsFailed = 0;
  int expMedida   = 0;
  bit expErro     = 1'b0;
  int curM        = -1;

  // Units for m counted cycles: whole units plus an optional half-up bump.
  function automatic int expectedUnits(input int m);
    int v;
    v = m / R;
    if (ROUND && ((m % R) >= (R / 2))) v++;
    return v;
  endfunction

  function automatic logic [31:0] toBcd(input int v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < DIGITOS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s (m=%0d): observed %0h expected %0h", tag, curM, observed, expected);
    end
  endtask

  // One echo pulse giving m counted cycles (pulse held m+1 clocks), then a quiet gap.
  task automatic applyStimulus(input int m, input int gap);
    int p, kp, kEnd, prontos;
    bit timedOut;
    p        = m + 1;
    timedOut = (m >= TIMEOUT_CM * R);
    kp       = timedOut ? TIMEOUT_CM * R + 3 : p + 3;
    kEnd     = ((p > kp) ? p : kp) + gap;
    prontos  = 0;
    curM     = m;
    bus.pulso = 1'b1;
    for (int k = 1; k <= kEnd; k++) begin
      @(negedge clock);
      if (bus.pronto === 1'b1) prontos++;
      if (k == 1) begin
        checkOutput("ocupadoBeforeEdge", bus.ocupado, 0);
        checkOutput("erroHeldUntilEdge", bus.erro, expErro);
      end
      if (k == 2) begin
        checkOutput("ocupadoRise", bus.ocupado, 1);
        checkOutput("erroCleared", bus.erro, 0);
      end
      if (timedOut && (k == kp - 1)) checkOutput("erroNotEarly", bus.erro, 0);
      if (k == kp) begin
        checkOutput("prontoStrobe", bus.pronto, 1);
        if (timedOut) begin
          checkOutput("erroSet", bus.erro, 1);
        end else begin
          expMedida = expectedUnits(m);
          checkOutput("erroValid", bus.erro, 0);
        end
        checkOutput("medidaAtPronto", bus.medida, expMedida);
        checkOutput("digitosAtPronto", bus.digitos, toBcd(expMedida));
      end
      if (k == p) bus.pulso = 1'b0;
    end
    expErro = timedOut;
    checkOutput("prontoCount", prontos, 1);
    checkOutput("ocupadoIdle", bus.ocupado, 0);
    checkOutput("erroAfter", bus.erro, expErro);
    checkOutput("medidaHeld", bus.medida, expMedida);
    checkOutput("digitosHeld", bus.digitos, toBcd(expMedida));
  endtask

  task automatic resetMidPulse();
    int prontos;
    prontos   = 0;
    curM      = -1;
    bus.pulso = 1'b1;
    repeat (40) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("rstPronto", bus.pronto, 0);
    checkOutput("rstOcupado", bus.ocupado, 0);
    checkOutput("rstErro", bus.erro, 0);
    checkOutput("rstMedida", bus.medida, 0);
    checkOutput("rstDigitos", bus.digitos, 0);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (bus.pronto === 1'b1) prontos++;
      if (k == 5) checkOutput("ignoredOcupado", bus.ocupado, 0);
    end
    bus.pulso = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (bus.pronto === 1'b1) prontos++;
    end
    checkOutput("rstNoPronto", prontos, 0);
    checkOutput("rstMedidaStill", bus.medida, 0);
    expMedida = 0;
    expErro   = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bus.pulso = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("resetPronto", bus.pronto, 0);
    checkOutput("resetOcupado", bus.ocupado, 0);
    checkOutput("resetErro", bus.erro, 0);
    checkOutput("resetMedida", bus.medida, 0);
    checkOutput("resetDigitos", bus.digitos, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    applyStimulus(700, 4);
    applyStimulus(706, 3);
    applyStimulus(702, 5);
    applyStimulus(703, 3);
    applyStimulus(0, 3);
    applyStimulus(2, 4);
    applyStimulus(518, 3);
    applyStimulus(1300, 4);
    applyStimulus(700, 3);
    applyStimulus(69, 3);
    applyStimulus(699, 3);
    applyStimulus(TIMEOUT_CM * R - 1, 3);
    applyStimulus(TIMEOUT_CM * R, 5);
    resetMidPulse();
    applyStimulus(518, 3);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(int'($urandom_range(1150, 0)), int'($urandom_range(8, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
